frame_rate_meter: RTL and testbench

Multi-channel, fixed-point successor to the single-channel FPS counter. It counts event pulses on `NUM_CH` independent channels over a window of `WINDOW_SEC` seconds. At each window end it snapshots every channel without losing any events. A single shared bit-serial divider then computes each channel's rate as events per second, with `FRAC_BITS` fractional bits. The block sits beside the renderer and display pipeline, takes per-stage "frame done" strobes, and feeds the on-screen statistics overlay.

---
 rtl/frame_rate_meter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_frame_rate_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rate_meter.sv
// frame_rate_meter: per-channel windowed event counters feeding one shared bit-serial divider.
// Reports events/second in fixed point; `FRAME_RATE_METER_MINMAX_EN adds per-channel min/max tracking.
module frame_rate_meter #(
  parameter int NUM_CH         = 2,
  parameter int WIDTH          = 32,
  parameter int FRAC_BITS      = 4,
  parameter int CYCLES_PER_SEC = 4_000_000,
  parameter int WINDOW_SEC     = 5
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_CH-1:0]              event_in,
  input  logic                           clear_in,
  output logic [NUM_CH-1:0][WIDTH-1:0]   rate_out,
  output logic [NUM_CH-1:0]              rate_valid_out,
  output logic [NUM_CH-1:0]              overflow_out,
`ifdef FRAME_RATE_METER_MINMAX_EN
  output logic [NUM_CH-1:0][WIDTH-1:0]   min_out,
  output logic [NUM_CH-1:0][WIDTH-1:0]   max_out,
`endif
  output logic                           busy_out
);

  localparam int CNT_W = WIDTH - FRAC_BITS;
  localparam int CYC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int SEC_W = (WINDOW_SEC > 1) ? $clog2(WINDOW_SEC) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(WINDOW_SEC - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH:0]   DIVISOR  = (WIDTH + 1)'(WINDOW_SEC);

  if (FRAC_BITS >= WIDTH) begin : g_badFrac
    $error("frame_rate_meter: FRAC_BITS must be less than WIDTH");
  end
  if (WINDOW_SEC < 1) begin : g_badWindow
    $error("frame_rate_meter: WINDOW_SEC must be at least 1");
  end
  // Guarantees the divider has drained all channels before the next window closes.
  if (longint'(CYCLES_PER_SEC) * longint'(WINDOW_SEC) <= longint'(NUM_CH) * longint'(WIDTH + 2)) begin : g_badWindowLen
    $error("frame_rate_meter: CYCLES_PER_SEC*WINDOW_SEC must exceed NUM_CH*(WIDTH+2)");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE} state_t;

  state_t                        r_state;
  state_t                        w_stateNext;
  logic [CYC_W-1:0]              r_cycCnt;
  logic [SEC_W-1:0]              r_secCnt;
  logic                          w_secTick;
  logic                          w_winEnd;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_snap;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_cntInc;
  logic [NUM_CH-1:0]             w_sat;
  logic [NUM_CH-1:0]             r_ovf;
  logic                          r_pending;
  logic [CH_W-1:0]               r_chIdx;
  logic [BIT_W-1:0]              r_bitCnt;
  logic [WIDTH-1:0]              r_dvd;
  logic [WIDTH-1:0]              r_rem;
  logic [WIDTH-1:0]              w_remNext;
  logic [WIDTH-1:0]              w_quotNext;
  logic [WIDTH-1:0]              w_dividend;
  logic [WIDTH:0]                w_remShift;
  logic                          w_qBit;
  logic                          w_start;
  logic                          w_load;
  logic                          w_step;
  logic                          w_commit;
  logic                          w_advance;
  logic                          w_busy;
  logic [NUM_CH-1:0][WIDTH-1:0]  r_rate;
  logic [NUM_CH-1:0]             r_rateValid;

  assign w_secTick = (r_cycCnt == CYC_LAST);
  assign w_winEnd  = w_secTick && (r_secCnt == SEC_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cycCnt <= '0;
      r_secCnt <= '0;
    end else if (clear_in) begin
      r_cycCnt <= '0;
      r_secCnt <= '0;
    end else begin
      r_cycCnt <= w_secTick ? '0 : r_cycCnt + 1'b1;
      if (w_secTick) begin
        r_secCnt <= (r_secCnt == SEC_LAST) ? '0 : r_secCnt + 1'b1;
      end
    end
  end

  // An event arriving while a count is already all-ones is the one that gets lost.
  always_comb begin
    w_sat    = '0;
    w_cntInc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sat[k]    = event_in[k] && (r_cnt[k] == '1);
      w_cntInc[k] = r_cnt[k] + CNT_W'(event_in[k] && !w_sat[k]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_ovf  <= '0;
    end else if (clear_in) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_winEnd) begin
          r_snap[k] <= w_cntInc[k];
          r_cnt[k]  <= '0;
        end else begin
          r_cnt[k] <= w_cntInc[k];
        end
        if (w_sat[k]) begin
          r_ovf[k] <= 1'b1;
        end
      end
    end
  end

  // Restoring division: the dividend register fills with quotient bits as it shifts out.
  always_comb begin
    w_dividend = WIDTH'(r_snap[r_chIdx]) << FRAC_BITS;
    w_remShift = {r_rem, r_dvd[WIDTH-1]};
    w_qBit     = (w_remShift >= DIVISOR);
    w_remNext  = w_qBit ? WIDTH'(w_remShift - DIVISOR) : w_remShift[WIDTH-1:0];
    w_quotNext = {r_dvd[WIDTH-2:0], w_qBit};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (r_pending) w_stateNext = S_LOAD;
      S_LOAD:  w_stateNext = S_DIV;
      S_DIV:   if (r_bitCnt == '0) w_stateNext = S_WRITE;
      S_WRITE: w_stateNext = (r_chIdx == CH_LAST) ? S_IDLE : S_LOAD;
      default: w_stateNext = S_IDLE;
    endcase
    if (clear_in) begin
      w_stateNext = S_IDLE;
    end
  end

  // The final quotient is registered on the DIV->WRITE edge so it is visible for the whole WRITE cycle.
  always_comb begin
    w_start   = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_commit  = 1'b0;
    w_advance = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_start = r_pending;
      end
      S_LOAD:  w_load = 1'b1;
      S_DIV: begin
        w_step   = 1'b1;
        w_commit = (r_bitCnt == '0);
      end
      S_WRITE: w_advance = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pending <= 1'b0;
      r_chIdx   <= '0;
      r_bitCnt  <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
    end else if (clear_in) begin
      r_pending <= 1'b0;
      r_chIdx   <= '0;
      r_bitCnt  <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
    end else begin
      if (w_winEnd) begin
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
      if (w_start) begin
        r_chIdx <= '0;
      end else if (w_advance && (r_chIdx != CH_LAST)) begin
        r_chIdx <= r_chIdx + 1'b1;
      end
      if (w_load) begin
        r_dvd    <= w_dividend;
        r_rem    <= '0;
        r_bitCnt <= BIT_LAST;
      end else if (w_step) begin
        r_dvd    <= w_quotNext;
        r_rem    <= w_remNext;
        r_bitCnt <= r_bitCnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rate      <= '0;
      r_rateValid <= '0;
    end else begin
      r_rateValid <= '0;
      if (clear_in) begin
        r_rate <= '0;
      end else if (w_commit) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (r_chIdx == CH_W'(k)) begin
            r_rate[k]      <= w_quotNext;
            r_rateValid[k] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef FRAME_RATE_METER_MINMAX_EN
  logic [NUM_CH-1:0][WIDTH-1:0] r_min;
  logic [NUM_CH-1:0][WIDTH-1:0] r_max;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_min <= '1;
      r_max <= '0;
    end else if (clear_in) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_chIdx == CH_W'(k)) begin
          if (w_quotNext < r_min[k]) r_min[k] <= w_quotNext;
          if (w_quotNext > r_max[k]) r_max[k] <= w_quotNext;
        end
      end
    end
  end

  assign min_out = r_min;
  assign max_out = r_max;
`endif

  assign rate_out       = r_rate;
  assign rate_valid_out = r_rateValid;
  assign overflow_out   = r_ovf;
  assign busy_out       = w_busy;

endmodule

// File: tb/tb_frame_rate_meter.sv
// tb_frame_rate_meter: directed bench with 100-cycle seconds, 2-second windows and a 16-bit datapath.
// A second instance with FRAC_BITS=10 has channel 0 held high to exercise count saturation.
module tb_frame_rate_meter;

  logic             clkIn;
  logic             rstN;
  logic             clearIn;
  logic [1:0]       eventIn;
  logic [1:0]       satEvent;
  logic [1:0][15:0] rateOut;
  logic [1:0][15:0] satRateOut;
  logic [1:0]       rateValid;
  logic [1:0]       satRateValid;
  logic [1:0]       overflow;
  logic [1:0]       satOverflow;
  logic             busy;
  logic             satBusy;
`ifdef FRAME_RATE_METER_MINMAX_EN
  logic [1:0][15:0] minOut;
  logic [1:0][15:0] maxOut;
  logic [1:0][15:0] satMinOut;
  logic [1:0][15:0] satMaxOut;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int p0 = 0;
  int p1 = 0;
  bit useList = 0;
  bit stepMode = 0;
  bit validSeen = 0;
  int total = 0;
  int pulseList[10] = '{10, 50, 199, 200, 250, 300, 350, 399, 400, 599};

  frame_rate_meter #(
    .NUM_CH(2), .WIDTH(16), .FRAC_BITS(4), .CYCLES_PER_SEC(100), .WINDOW_SEC(2)
  ) dut (
    .clk_in(clkIn),
    .rst_n_in(rstN),
    .event_in(eventIn),
    .clear_in(clearIn),
    .rate_out(rateOut),
    .rate_valid_out(rateValid),
    .overflow_out(overflow),
`ifdef FRAME_RATE_METER_MINMAX_EN
    .min_out(minOut),
    .max_out(maxOut),
`endif
    .busy_out(busy)
  );

  frame_rate_meter #(
    .NUM_CH(2), .WIDTH(16), .FRAC_BITS(10), .CYCLES_PER_SEC(100), .WINDOW_SEC(2)
  ) dutSat (
    .clk_in(clkIn),
    .rst_n_in(rstN),
    .event_in(satEvent),
    .clear_in(clearIn),
    .rate_out(satRateOut),
    .rate_valid_out(satRateValid),
    .overflow_out(satOverflow),
`ifdef FRAME_RATE_METER_MINMAX_EN
    .min_out(satMinOut),
    .max_out(satMaxOut),
`endif
    .busy_out(satBusy)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic bit pulseAt(input int c, input int p);
    return (p > 0) && (c >= 0) && ((c % p) == 0);
  endfunction

  // Events for bench cycle cyc; cycle 0 is the first cycle after reset release or clear.
  task automatic driveEvents();
    bit e0;
    bit e1;
    int p;
    p = p0;
    if (stepMode) p = (cyc < 200) ? 10 : ((cyc < 400) ? 5 : 20);
    e0 = pulseAt(cyc, p);
    if (useList) begin
      foreach (pulseList[i]) if (pulseList[i] == cyc) e0 = 1'b1;
    end
    e1 = pulseAt(cyc, p1);
    eventIn  = {e1, e0};
    satEvent = {e1, 1'b1};
  endtask

  task automatic applyStimulus();
    @(posedge clkIn);
    #1;
    cyc++;
    driveEvents();
  endtask

  task automatic runTo(input int target);
    while (cyc < target) applyStimulus();
  endtask

  task automatic doReset();
    rstN     = 1'b0;
    clearIn  = 1'b0;
    eventIn  = '0;
    satEvent = '0;
    repeat (2) @(posedge clkIn);
    #1;
    checkOutput("rstRate", 32'(rateOut), 0);
    checkOutput("rstValid", 32'(rateValid), 0);
    checkOutput("rstOvf", 32'(satOverflow), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    rstN = 1'b1;
    cyc  = 0;
    driveEvents();
  endtask

  // Events forced high in the clear cycle must be discarded.
  task automatic clearAndRestart();
    clearIn  = 1'b1;
    eventIn  = 2'b11;
    satEvent = 2'b11;
    @(posedge clkIn);
    #1;
    clearIn = 1'b0;
    cyc     = 0;
    driveEvents();
  endtask

  initial begin
    rstN = 1'b0; clearIn = 1'b0; eventIn = '0; satEvent = '0;

    p0 = 10; p1 = 8;
    doReset();
    runTo(200); checkOutput("busyBeforeLoad", 32'(busy), 0);
    runTo(201); checkOutput("busyRise", 32'(busy), 1);
    runTo(217); checkOutput("validEarly", 32'(rateValid), 0);
    runTo(218);
    checkOutput("valid0", 32'(rateValid), 32'b01);
    checkOutput("rate0", 32'(rateOut[0]), 160);
    checkOutput("satRate0", 32'(satRateOut[0]), 32256);
    checkOutput("satOvf", 32'(satOverflow), 32'b01);
    checkOutput("ovfNone", 32'(overflow), 0);
    runTo(236);
    checkOutput("valid1", 32'(rateValid), 32'b10);
    checkOutput("rate1", 32'(rateOut[1]), 200);
    checkOutput("satRate1", 32'(satRateOut[1]), 12800);
    checkOutput("rate0Held", 32'(rateOut[0]), 160);
    runTo(237); checkOutput("busyFall", 32'(busy), 0);
    runTo(418);
    checkOutput("win2Valid0", 32'(rateValid), 32'b01);
    checkOutput("win2Rate0", 32'(rateOut[0]), 160);
    runTo(436); checkOutput("win2Rate1", 32'(rateOut[1]), 200);

    useList = 1; p0 = 0; p1 = 4;
    clearAndRestart();
    checkOutput("clearRate", 32'(rateOut), 0);
    checkOutput("clearSatOvf", 32'(satOverflow), 0);
    runTo(218); checkOutput("bndWin0", 32'(rateOut[0]), 24);
    total = int'(rateOut[0]);
    runTo(236); checkOutput("ch1Dense", 32'(rateOut[1]), 400);
    runTo(418); checkOutput("bndWin1", 32'(rateOut[0]), 40);
    total += int'(rateOut[0]);
    runTo(618); checkOutput("bndWin2", 32'(rateOut[0]), 16);
    total += int'(rateOut[0]);
    checkOutput("bndTotalPulses", 32'((total * 2) / 16), 10);

    useList = 0; p0 = 10; p1 = 8;
    clearAndRestart();
    runTo(205); checkOutput("busyMidDiv", 32'(busy), 1);
    clearAndRestart();
    checkOutput("clearBusy", 32'(busy), 0);
    checkOutput("clearNoPartial", 32'(rateOut), 0);
    validSeen = 1'b0;
    if (rateValid != 0) validSeen = 1'b1;
    while (cyc < 217) begin
      applyStimulus();
      if (rateValid != 0) validSeen = 1'b1;
    end
    checkOutput("noValidAfterClear", 32'(validSeen), 0);
    runTo(218);
    checkOutput("postClearValid", 32'(rateValid), 32'b01);
    checkOutput("postClearRate0", 32'(rateOut[0]), 160);

    runTo(225);
    checkOutput("busyBeforeRst", 32'(busy), 1);
    checkOutput("satOvfBeforeRst", 32'(satOverflow), 32'b01);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRate", 32'(rateOut), 0);
    checkOutput("asyncValid", 32'(rateValid), 0);
    checkOutput("asyncOvf", 32'(satOverflow), 0);
    checkOutput("asyncBusy", 32'(busy), 0);
    doReset();
    runTo(218);
    checkOutput("rerunValid0", 32'(rateValid), 32'b01);
    checkOutput("rerunRate0", 32'(rateOut[0]), 160);
    runTo(236); checkOutput("rerunRate1", 32'(rateOut[1]), 200);

`ifdef FRAME_RATE_METER_MINMAX_EN
    clearAndRestart();
    checkOutput("mmClearMin", 32'(minOut), 32'hFFFF_FFFF);
    checkOutput("mmClearMax", 32'(maxOut), 0);
    stepMode = 1;
    runTo(218);
    checkOutput("mmFirstMax", 32'(maxOut[0]), 160);
    checkOutput("mmFirstMin", 32'(minOut[0]), 160);
    runTo(618);
    checkOutput("mmMax", 32'(maxOut[0]), 320);
    checkOutput("mmMin", 32'(minOut[0]), 80);
    stepMode = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
